ahb_cmd_master: RTL
===================

// Module: ahb_cmd_master
// PURPOSE
// - AHB-Lite master sitting directly upstream of ahb_slave. Converts a valid/ready command
//   stream (read/write, addr, wdata) into pipelined single NONSEQ transfers and returns a
//   response pulse, with read data, for every completed transfer.
// - Honours slave wait states (hready low) and sustains one transfer per cycle back-to-back.
// PARAMETERS
// - AW      8   address width (haddr, cmd_addr)
// - DW      32  data width (hwdata, hrdata, cmd_wdata, rsp_rdata)
// - WCNT_W  16  width of the wait-state statistics counter
// PORTS
// - hclk        in   1       clock; all logic on rising edge
// - hresetn     in   1       reset, asynchronous, active-low
// - cmd_valid   in   1       command offered
// - cmd_ready   out  1       command accepted when cmd_valid&cmd_ready at posedge
// - cmd_write   in   1       1=write, 0=read
// - cmd_addr    in   AW      transfer address
// - cmd_wdata   in   DW      write data (ignored for reads)
// - rsp_valid   out  1       one-cycle pulse per completed transfer; no backpressure
// - rsp_write   out  1       direction of completed transfer
// - rsp_rdata   out  DW      read data (0 for writes)
// - htrans      out  2       AHB transfer type: 2'b00 IDLE, 2'b10 NONSEQ only
// - hwrite      out  1       AHB direction
// - haddr       out  AW      AHB address
// - hwdata      out  DW      AHB write data (data phase)
// - hready      in   1       AHB ready from slave; low = wait state
// - hrdata      in   DW      AHB read data from slave
// - busy        out  1       address or data phase occupied
// - wait_cnt    out  WCNT_W  count of data-phase cycles with hready=0, saturating
// BEHAVIOUR
// - Two pipeline registers: AP (valid, write, addr, wdata) drives htrans/hwrite/haddr;
//   DP (valid, write, wdata) drives hwdata. All AHB outputs registered.
// - cmd_ready = hready (combinational). Accept at posedge with cmd_valid&hready -> AP.
// - At posedge with hready=1: DP <= AP; AP <= accepted cmd, else AP.valid <= 0.
// - At posedge with hready=0: AP, DP, and all AHB outputs hold; no command accepted.
// - htrans = AP.valid ? 2'b10 : 2'b00. hwdata = DP.wdata while DP.valid && DP.write.
// - Latency: cmd accepted edge N -> address phase cycle N+1 -> data phase cycle N+2
//   (+ wait states) -> rsp_valid high the cycle after the data phase completes.
// - Completion: posedge with DP.valid && hready=1. Next cycle rsp_valid=1,
//   rsp_write=DP.write, rsp_rdata = read ? hrdata sampled at that edge : 0.
// - Throughput: back-to-back commands with hready=1 give one NONSEQ per cycle;
//   mixed read/write ordering is preserved, with one response per command in issue order.
// - wait_cnt increments on each posedge with DP.valid && !hready; saturates at all-ones,
//   never wraps. busy = AP.valid | DP.valid.
// - Reset values: cmd_ready follows hready; htrans=0, hwrite=0, haddr=0, hwdata=0,
//   rsp_valid=0, rsp_write=0, rsp_rdata=0, busy=0, wait_cnt=0; AP.valid=DP.valid=0.
// - Reset mid-transfer: in-flight AP/DP are dropped, with no rsp_valid for them.
//   wait_cnt clears. The first command after reset release behaves as from idle.
// - Idle between commands: htrans returns to IDLE in the cycle after the last address phase.
// - hready low with AP IDLE: htrans stays IDLE; the pending cmd waits for hready.
// CONFIGURATION
// - AHB_MST_IDLE_X_EN defined: when the phase is not active, haddr and hwrite
//   (AP.valid=0) and hwdata (DP.valid=0 or read) drive 'x, including during reset.
//   htrans is always 0 when idle.
// - Not defined: those outputs drive 0 instead of 'x. Behaviour is otherwise identical.
// TESTING
// - Single write addr 8'h0d data 32'h5a5a_5a5a, hready=1 -> htrans=2'b10 cycle 1,
//   hwdata=5a5a_5a5a cycle 2, rsp_valid cycle 3, rsp_write=1, slave mem[0d]=5a5a_5a5a.
// - Preload mem[8'h1d]=32'hdead_beef, single read 8'h1d -> rsp_valid once,
//   rsp_write=0, rsp_rdata=dead_beef, htrans=IDLE after address phase.
// - 3 back-to-back writes (99,fff),(98,ffe),(97,ffd) then read 99 -> NONSEQ on 4
//   consecutive cycles, 4 rsp pulses in order, read returns fff.
// - Write 8'hfc data 32'hff with 8-cycle slave busy -> hwdata=ff held all 8 wait cycles,
//   cmd_ready=0 throughout, wait_cnt=8, mem[fc] written only after hready rises.
// - hresetn low during a read data phase -> no rsp_valid, htrans=0, busy=0,
//   wait_cnt=0; the next read after release completes normally.
// - Force hready=0 for 2^WCNT_W+5 cycles with WCNT_W=4 -> wait_cnt sticks at 4'hf;
//   with and without AHB_MST_IDLE_X_EN, check haddr idle value is 'x / 0.

Source files
------------

// File: rtl/ahb_cmd_master.sv
// rtl/ahb_cmd_master.sv - AHB-Lite master turning a command stream into single NONSEQ transfers
//
// Converts valid/ready commands (read/write, addr, wdata) into pipelined AHB-Lite
// single transfers. Each completed transfer produces a one-cycle response pulse.
// Address phase (AP) and data phase (DP) are separate register stages, so a new
// transfer can be issued every cycle while hready is high.
//
// Optional build macro: AHB_MST_IDLE_X_EN
//   defined   : haddr/hwrite drive 'x when no address phase is active, and hwdata
//               drives 'x outside a write data phase
//   undefined : those outputs drive 0 when inactive
//
// Ports
//   hclk, hresetn                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready = hready)
//   cmd_write/cmd_addr/cmd_wdata  command payload
//   rsp_valid/rsp_write/rsp_rdata one-cycle response per completed transfer
//   htrans/hwrite/haddr/hwdata    AHB-Lite master outputs
//   hready/hrdata                 AHB-Lite slave inputs
//   busy                          AP or DP occupied
//   wait_cnt                      saturating count of data-phase wait states

module ahb_cmd_master #(
   parameter int AW     = 8,
   parameter int DW     = 32,
   parameter int WCNT_W = 16
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [AW-1:0]     cmd_addr,
   input  logic [DW-1:0]     cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [DW-1:0]     rsp_rdata,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [AW-1:0]     haddr,
   output logic [DW-1:0]     hwdata,
   input  logic              hready,
   input  logic [DW-1:0]     hrdata,
   output logic              busy,
   output logic [WCNT_W-1:0] wait_cnt
);

   // Address-phase stage
   logic          ap_valid;
   logic          ap_write;
   logic [AW-1:0] ap_addr;
   logic [DW-1:0] ap_wdata;

   // Data-phase stage; dp_wdata is held at 0 unless a write occupies the stage
   logic          dp_valid;
   logic          dp_write;
   logic [DW-1:0] dp_wdata;

   // A command can only be taken when the bus pipeline advances
   assign cmd_ready = hready;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         ap_valid  <= 1'b0;
         ap_write  <= 1'b0;
         ap_addr   <= '0;
         ap_wdata  <= '0;
         dp_valid  <= 1'b0;
         dp_write  <= 1'b0;
         dp_wdata  <= '0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         wait_cnt  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (hready) begin
            // Data phase completes at this edge: report it and advance the pipe
            if (dp_valid) begin
               rsp_valid <= 1'b1;
               rsp_write <= dp_write;
               rsp_rdata <= dp_write ? '0 : hrdata;
            end
            dp_valid <= ap_valid;
            dp_write <= ap_valid & ap_write;
            dp_wdata <= (ap_valid && ap_write) ? ap_wdata : '0;
            if (cmd_valid) begin
               ap_valid <= 1'b1;
               ap_write <= cmd_write;
               ap_addr  <= cmd_addr;
               ap_wdata <= cmd_wdata;
            end else begin
               // Clearing the payload keeps the idle bus values at 0
               ap_valid <= 1'b0;
               ap_write <= 1'b0;
               ap_addr  <= '0;
               ap_wdata <= '0;
            end
         end else if (dp_valid && (wait_cnt != {WCNT_W{1'b1}})) begin
            // Everything holds during a wait state; only the statistic moves
            wait_cnt <= wait_cnt + WCNT_W'(1);
         end
      end
   end

   assign htrans = {ap_valid, 1'b0};
   assign busy   = ap_valid | dp_valid;

`ifdef AHB_MST_IDLE_X_EN
   assign haddr  = ap_valid ? ap_addr  : {AW{1'bx}};
   assign hwrite = ap_valid ? ap_write : 1'bx;
   assign hwdata = (dp_valid && dp_write) ? dp_wdata : {DW{1'bx}};
`else
   assign haddr  = ap_addr;
   assign hwrite = ap_write;
   assign hwdata = dp_wdata;
`endif

endmodule
